// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and the
// datapath select codes driven by the control FSM.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BEQ  = 2'b01;
    localparam logic [1:0] PCSRC_BNE  = 2'b10;
    localparam logic [1:0] PCSRC_JUMP = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:   return S_MEMADDR;
            OP_RTYPE:       return S_REXEC;
            OP_ADDI:        return S_IEXEC;
            OP_BEQ, OP_BNE: return S_BRANCH;
            OP_J:           return S_JUMP;
            OP_JAL:         return S_JAL;
            default:        return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath; outputs decode from the
// registered state, except FETCH's IR/PC writes which qualify on MemReady.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_opcode <= OP_RTYPE;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_opcode <= Opcode;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = decode_next(Opcode);
            // Opcode may already be changing here; use the copy captured in DECODE.
            S_MEMADDR: w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = MemReady ? S_FETCH : S_MEMWR;
            S_REXEC:   w_next = S_RWB;
            S_RWB:     w_next = S_FETCH;
            S_IEXEC:   w_next = S_IWB;
            S_IWB:     w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_JAL:     w_next = S_FETCH;
            S_ILLEGAL: w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = PCSRC_PC4;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALUOP_ADD;
        RegDst      = REGDST_RT;
        MemtoReg    = MTR_ALUOUT;
        Illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // Held-off while reset is asserted so no PC/IR update leaks out.
                PCWrite = MemReady & ~reset;
                IRWrite = MemReady & ~reset;
            end
            S_DECODE: ALUSrcB = SRCB_IMM_SH2;
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_MDR;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RD;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_IWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = (r_opcode == OP_BNE) ? PCSRC_BNE : PCSRC_BEQ;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                RegWrite = 1'b1;
                RegDst   = REGDST_RA;
                MemtoReg = MTR_PC;
            end
            S_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end

    assign State = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level bench for multicycle_ctrl: builds each
// instruction's expected state walk and checks every cycle's outputs.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg;
    logic       Illegal;
    logic [3:0] State;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [22:0] exp_vec;
    logic        exp_valid = 1'b0;
    int          pin_en = 0;
    int          mw_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    // Spec output table, written with literal codes independent of the package.
    function automatic logic [22:0] model(input state_t st, input logic [5:0] op, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, asa, ill;
        logic [1:0] pcs, asb, aop, rd, mtr;
        {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, ill} = '0;
        {pcs, asb, aop, rd, mtr} = '0;
        case (st)
            S_FETCH:   begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            S_DECODE:  asb = 2'b11;
            S_MEMADDR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:   begin mrd = 1; iord = 1; end
            S_MEMWB:   begin rw = 1; mtr = 2'b01; end
            S_MEMWR:   begin mwr = 1; iord = 1; end
            S_REXEC:   begin asa = 1; aop = 2'b10; end
            S_RWB:     begin rw = 1; rd = 2'b01; end
            S_IEXEC:   begin asa = 1; asb = 2'b10; end
            S_IWB:     rw = 1;
            S_BRANCH:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = (op == 6'b000101) ? 2'b10 : 2'b01; end
            S_JUMP:    begin pcw = 1; pcs = 2'b11; end
            S_JAL:     begin pcw = 1; pcs = 2'b11; rw = 1; rd = 2'b10; mtr = 2'b10; end
            S_ILLEGAL: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, pcs, asb, aop, rd, mtr, ill, 4'(st)};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000,
                          6'b000100, 6'b000101, 6'b000010, 6'b000011};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            check("cycle_outputs",
                  32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                       PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg, Illegal, State}),
                  32'(exp_vec));
        end
    end

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic step(input state_t st, input logic [5:0] op, input logic mr);
        MemReady  = mr;
        Opcode    = (st == S_DECODE) ? op : 6'($urandom);
        exp_vec   = model(st, op, mr);
        exp_valid = 1'b1;
        #4;
        if (pin_en != 0) begin
            if (st == S_MEMWR) mw_seen += int'(MemWrite);
            if (st == S_BRANCH && op == 6'b000101) begin
                check("bne_pcsource", 32'(PCSource), 32'd2);
                check("bne_aluop", 32'(ALUOp), 32'd1);
                check("bne_pcwritecond", 32'(PCWriteCond), 32'd1);
            end
            if (st == S_JAL) begin
                check("jal_regdst", 32'(RegDst), 32'd2);
                check("jal_memtoreg", 32'(MemtoReg), 32'd2);
                check("jal_writes", 32'({PCWrite, RegWrite, PCSource}), 32'b1111);
            end
            if (st == S_ILLEGAL)
                check("illegal_pulse", 32'({Illegal, RegWrite, MemWrite, PCWrite}), 32'b1000);
            if (st == S_MEMWB)
                check("lw_memwb", 32'({RegWrite, MemtoReg}), 32'b101);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int exp_len);
        state_t seq[$];
        logic   mrq[$];
        for (int i = 0; i < fw; i++) begin seq.push_back(S_FETCH); mrq.push_back(1'b0); end
        seq.push_back(S_FETCH);  mrq.push_back(1'b1);
        seq.push_back(S_DECODE); mrq.push_back(1'($urandom));
        case (op)
            6'b100011: begin
                seq.push_back(S_MEMADDR); mrq.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin seq.push_back(S_MEMRD); mrq.push_back(1'b0); end
                seq.push_back(S_MEMRD); mrq.push_back(1'b1);
                seq.push_back(S_MEMWB); mrq.push_back(1'($urandom));
            end
            6'b101011: begin
                seq.push_back(S_MEMADDR); mrq.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin seq.push_back(S_MEMWR); mrq.push_back(1'b0); end
                seq.push_back(S_MEMWR); mrq.push_back(1'b1);
            end
            6'b000000: begin
                seq.push_back(S_REXEC); mrq.push_back(1'($urandom));
                seq.push_back(S_RWB);   mrq.push_back(1'($urandom));
            end
            6'b001000: begin
                seq.push_back(S_IEXEC); mrq.push_back(1'($urandom));
                seq.push_back(S_IWB);   mrq.push_back(1'($urandom));
            end
            6'b000100, 6'b000101: begin seq.push_back(S_BRANCH);  mrq.push_back(1'($urandom)); end
            6'b000010:            begin seq.push_back(S_JUMP);    mrq.push_back(1'($urandom)); end
            6'b000011:            begin seq.push_back(S_JAL);     mrq.push_back(1'($urandom)); end
            default:              begin seq.push_back(S_ILLEGAL); mrq.push_back(1'($urandom)); end
        endcase
        if (exp_len >= 0) check("cycle_count", 32'(seq.size()), 32'(exp_len));
        foreach (seq[i]) step(seq[i], op, mrq[i]);
    endtask

    initial begin
        logic [5:0] legal_ops [8];
        logic [5:0] op;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                      6'b000100, 6'b000101, 6'b000010, 6'b000011};
        reset = 1'b1; MemReady = 1'b1; Opcode = 6'b000000;
        #2;
        check("reset_state", 32'(State), 32'd0);
        check("reset_fetch_outs", 32'({MemRead, PCWrite, IRWrite, ALUSrcB}), 32'b10001);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        pin_en = 1;
        run_instr(6'b100011, 0, 0, 5);
        mw_seen = 0;
        run_instr(6'b101011, 0, 3, 7);
        check("sw_memwrite_cycles", 32'(mw_seen), 32'd4);
        run_instr(6'b000101, 0, 0, 3);
        run_instr(6'b000011, 0, 0, 3);
        run_instr(6'b111111, 0, 0, 3);
        run_instr(6'b000000, 0, 0, 4);
        run_instr(6'b001000, 0, 0, 4);
        run_instr(6'b000100, 1, 0, 4);
        pin_en = 0;

        // Reset during a stalled store: access must abort immediately.
        step(S_FETCH, 6'b101011, 1'b1);
        step(S_DECODE, 6'b101011, 1'b0);
        step(S_MEMADDR, 6'b101011, 1'b0);
        exp_valid = 1'b0;
        MemReady = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_state", 32'(State), 32'd0);
        check("rst_mid_outs", 32'({MemWrite, MemRead, PCWrite, IRWrite, IorD}), 32'b01000);
        @(posedge clk);
        #1;
        check("rst_held_memwrite", 32'({MemWrite, State}), 32'd0);
        reset = 1'b0;
        run_instr(6'b000010, 0, 0, 3);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 8) == 8) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            run_instr(op, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, -1);
        end

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
